// File: rtl/ps2_cmd_sequencer_if.sv
// Handshake bundle between the PS/2 command sequencer, the input controller
// and the PS/2 transmitter/receiver pair.
interface ps2_cmd_sequencer_if;
    logic       start;
    logic [7:0] txCommand;
    logic       txSend;
    logic       txDone;
    logic [7:0] rxData;
    logic       rxValid;
    logic       busy;
    logic       initDone;
    logic       error;
    logic [2:0] step;

    // master drives requests and PS/2 events; slave is the sequencer itself
    modport master (output start, txDone, rxData, rxValid,
                    input  txCommand, txSend, busy, initDone, error, step);
    modport slave  (input  start, txDone, rxData, rxValid,
                    output txCommand, txSend, busy, initDone, error, step);
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 mouse init sequencer: sends the command list, checks ACK/BAT/ID, retries.
// Optional macro PS2_SEQ_SAMPLE_RATE_EN inserts "set sample rate 200" before enable.
module ps2_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input logic                  slowClk,
    input logic                  reset,
    ps2_cmd_sequencer_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

`ifdef PS2_SEQ_SAMPLE_RATE_EN
    localparam logic [2:0] LAST_STEP = 3'd3;
`else
    localparam logic [2:0] LAST_STEP = 3'd1;
`endif

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SEND     = 4'd1;
    localparam logic [3:0] S_WAIT_TX  = 4'd2;
    localparam logic [3:0] S_WAIT_ACK = 4'd3;
    localparam logic [3:0] S_WAIT_BAT = 4'd4;
    localparam logic [3:0] S_WAIT_ID  = 4'd5;
    localparam logic [3:0] S_NEXT     = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;

    function automatic logic [7:0] cmd_at(input logic [2:0] idx);
`ifdef PS2_SEQ_SAMPLE_RATE_EN
        case (idx)
            3'd0:    return 8'hFF;
            3'd1:    return 8'hF3;
            3'd2:    return 8'hC8;
            default: return 8'hF4;
        endcase
`else
        case (idx)
            3'd0:    return 8'hFF;
            default: return 8'hF4;
        endcase
`endif
    endfunction

    logic [3:0]    state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    txCommand_q, txCommand_d;
    logic          txSend_q, txSend_d;
    logic          busy_q, busy_d;
    logic          initDone_q, initDone_d;
    logic          error_q, error_d;
    logic          timeout, do_retry;

    assign timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        tcnt_d      = '0;
        txCommand_d = txCommand_q;
        txSend_d    = 1'b0;
        busy_d      = busy_q;
        initDone_d  = initDone_q;
        error_d     = error_q;
        do_retry    = 1'b0;

        // A response byte is checked before the timeout, so it wins a tie.
        case (state_q)
            S_IDLE: if (bus.start) begin
                initDone_d = 1'b0;
                error_d    = 1'b0;
                step_d     = '0;
                retry_d    = '0;
                busy_d     = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                txCommand_d = cmd_at(step_q);
                txSend_d    = 1'b1;
                state_d     = S_WAIT_TX;
            end
            S_WAIT_TX: if (bus.txDone) state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (bus.rxValid && bus.rxData == 8'hFA)
                    state_d = (txCommand_q == 8'hFF) ? S_WAIT_BAT : S_NEXT;
                else if ((bus.rxValid && bus.rxData == 8'hFE) || timeout)
                    do_retry = 1'b1;
                else
                    tcnt_d = tcnt_q + 1'b1;
            end
            S_WAIT_BAT: begin
                if (bus.rxValid && bus.rxData == 8'hAA)
                    state_d = S_WAIT_ID;
                else if ((bus.rxValid && bus.rxData == 8'hFC) || timeout)
                    do_retry = 1'b1;
                else
                    tcnt_d = tcnt_q + 1'b1;
            end
            S_WAIT_ID: begin
                if (bus.rxValid && bus.rxData == 8'h00)
                    state_d = S_NEXT;
                else if (timeout)
                    do_retry = 1'b1;
                else
                    tcnt_d = tcnt_q + 1'b1;
            end
            S_NEXT: begin
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    retry_d = '0;
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                initDone_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            S_FAIL: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_retry) begin
            if (retry_q < RW'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                state_d = S_SEND;
            end else begin
                state_d = S_FAIL;
            end
        end
    end

    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            retry_q     <= '0;
            tcnt_q      <= '0;
            txCommand_q <= '0;
            txSend_q    <= 1'b0;
            busy_q      <= 1'b0;
            initDone_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            tcnt_q      <= tcnt_d;
            txCommand_q <= txCommand_d;
            txSend_q    <= txSend_d;
            busy_q      <= busy_d;
            initDone_q  <= initDone_d;
            error_q     <= error_d;
        end
    end

    assign bus.txCommand = txCommand_q;
    assign bus.txSend    = txSend_q;
    assign bus.busy      = busy_q;
    assign bus.initDone  = initDone_q;
    assign bus.error     = error_q;
    assign bus.step      = step_q;
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Randomised bench for ps2_cmd_sequencer: a device model answers each command
// from a per-run plan; a transaction-level model predicts sends and final status.
module tb_ps2_cmd_sequencer;
    localparam int TO = 256;
    localparam int MR = 3;
`ifdef PS2_SEQ_SAMPLE_RATE_EN
    localparam int NSTEP = 4;
`else
    localparam int NSTEP = 2;
`endif

    logic slowClk = 1'b0;
    logic reset   = 1'b1;
    ps2_cmd_sequencer_if bus();

    ps2_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .slowClk (slowClk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 slowClk = ~slowClk;

    int cyc = 0;
    always @(posedge slowClk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int sends = 0;
    int exp_at = 0;
    logic [7:0] expq[$];
    logic [7:0] sent_log[$];

    // plan: per step, number of failed attempts and how each one fails
    // kinds: 1 NACK, 2 ACK timeout, 3 BAT 0xFC, 4 BAT timeout, 5 ID timeout
    int fails[4];
    int kinds[4][5];
    bit e_done, e_fail;
    int e_step, e_sends;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] cmd_of(int s);
`ifdef PS2_SEQ_SAMPLE_RATE_EN
        logic [7:0] l[4] = '{8'hFF, 8'hF3, 8'hC8, 8'hF4};
`else
        logic [7:0] l[2] = '{8'hFF, 8'hF4};
`endif
        return l[s];
    endfunction

    function automatic bit qual(int ph, logic [7:0] b);
        case (ph)
            1:       return (b == 8'hFA) || (b == 8'hFE);
            2:       return (b == 8'hAA) || (b == 8'hFC);
            3:       return (b == 8'h00);
            default: return 1'b0;
        endcase
    endfunction

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic tick();
        @(posedge slowClk);
        #1;
        bus.start   = 1'b0;
        bus.txDone  = 1'b0;
        bus.rxValid = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_txCommand"}, bus.txCommand, 8'h00);
        chk({tag, "_txSend"},    bus.txSend,    0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_initDone"},  bus.initDone,  0);
        chk({tag, "_error"},     bus.error,     0);
        chk({tag, "_step"},      bus.step,      0);
    endtask

    // ph 0 = transmit in progress, 1/2/3 = waiting for ACK/BAT/ID
    task automatic noise(int ph, int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            tick();
            if ($urandom_range(1, 0) == 1) begin
                do b = 8'($urandom); while (qual(ph, b));
                bus.rxData  = b;
                bus.rxValid = 1'b1;
            end else if ($urandom_range(3, 0) == 0) begin
                bus.start = 1'b1;
            end else if (ph != 0 && $urandom_range(3, 0) == 0) begin
                bus.txDone = 1'b1;
            end
        end
    endtask

    task automatic respond(int ph, int trig, logic [7:0] b, bit late, output int a);
        if (late) begin
            while (cyc < trig + TO - 1) tick();
        end else begin
            noise(ph, $urandom_range(5, 0));
        end
        tick();
        bus.rxData  = b;
        bus.rxValid = 1'b1;
        a = cyc;
    endtask

    task automatic wait_send();
        bit ok = 1'b0;
        for (int i = 0; i < TO + 64; i++) begin
            tick();
            if (bus.txSend) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_arrives", int'(ok), 1);
        if (!ok) finish_now();
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * TO + 64; i++) begin
            tick();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("busy_drops", int'(ok), 1);
    endtask

    task automatic attempt(int s, int kind);
        int d, a, a2, a3;
        bit lt;
        wait_send();
        noise(0, $urandom_range(4, 0));
        tick();
        bus.txDone = 1'b1;
        d = cyc;
        lt = ($urandom_range(7, 0) == 0);
        if (kind == 1) begin
            respond(1, d, 8'hFE, 1'b0, a);
            exp_at = a + 2;
        end else if (kind == 2) begin
            noise(1, $urandom_range(4, 0));
            exp_at = d + TO + 2;
        end else begin
            respond(1, d, 8'hFA, lt, a);
            exp_at = 0;
            if (s == 0) begin
                if (kind == 3) begin
                    respond(2, a, 8'hFC, 1'b0, a2);
                    exp_at = a2 + 2;
                end else if (kind == 4) begin
                    noise(2, $urandom_range(4, 0));
                    exp_at = a + TO + 2;
                end else begin
                    respond(2, a, 8'hAA, lt, a2);
                    if (kind == 5) begin
                        noise(3, $urandom_range(4, 0));
                        exp_at = a2 + TO + 2;
                    end else begin
                        respond(3, a2, 8'h00, lt, a3);
                    end
                end
            end
        end
    endtask

    task automatic run_plan();
        int n, base;
        // transaction-level prediction of the whole run
        expq.delete();
        sent_log.delete();
        e_done = 1'b1; e_fail = 1'b0; e_step = NSTEP - 1; e_sends = 0;
        for (int s = 0; s < NSTEP; s++) begin
            n = (fails[s] > MR) ? MR + 1 : fails[s] + 1;
            for (int k = 0; k < n; k++) expq.push_back(cmd_of(s));
            e_sends += n;
            if (fails[s] > MR) begin
                e_done = 1'b0; e_fail = 1'b1; e_step = s;
                break;
            end
        end
        base = sends;
        tick();
        bus.start = 1'b1;
        exp_at = cyc + 2;
        tick();
        chk("busy_after_start", bus.busy, 1);
        chk("initDone_cleared", bus.initDone, 0);
        chk("error_cleared", bus.error, 0);
        for (int s = 0; s < NSTEP; s++) begin
            n = (fails[s] > MR) ? MR + 1 : fails[s] + 1;
            for (int k = 0; k < n; k++) attempt(s, (k < fails[s]) ? kinds[s][k] : 0);
            if (fails[s] > MR) break;
        end
        wait_idle();
        chk("initDone", bus.initDone, int'(e_done));
        chk("error", bus.error, int'(e_fail));
        chk("step", bus.step, e_step);
        chk("send_count", sends - base, e_sends);
        chk("all_expected_sent", expq.size(), 0);
    endtask

    task automatic clear_plan();
        for (int s = 0; s < 4; s++) begin
            fails[s] = 0;
            for (int k = 0; k < 5; k++) kinds[s][k] = 0;
        end
    endtask

    task automatic monitor();
        bit prev = 1'b0, outst = 1'b0, have = 1'b0;
        logic [7:0] held = 8'h00;
        forever begin
            @(negedge slowClk);
            if (reset) begin
                prev = 1'b0; outst = 1'b0; have = 1'b0;
            end else begin
                if (bus.txDone) outst = 1'b0;
                if (prev) chk("txSend_one_cycle", bus.txSend, 0);
                if (bus.txSend) begin
                    sends++;
                    sent_log.push_back(bus.txCommand);
                    chk("send_expected", int'(expq.size() > 0), 1);
                    if (expq.size() > 0) chk("txCommand", bus.txCommand, expq.pop_front());
                    if (exp_at != 0) chk("send_cycle", cyc, exp_at);
                    chk("busy_on_send", bus.busy, 1);
                    chk("send_after_done", int'(outst), 0);
                    outst = 1'b1;
                    held  = bus.txCommand;
                    have  = 1'b1;
                end else if (have) begin
                    chk("txCommand_stable", bus.txCommand, held);
                end
                prev = bus.txSend;
            end
        end
    endtask

    initial begin
        int base, cnt, a, d;
        logic [7:0] lit[$];
        bus.start = 1'b0; bus.txDone = 1'b0; bus.rxValid = 1'b0; bus.rxData = 8'h00;
        fork monitor(); join_none
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        repeat (2) tick();

        // nominal run, with literal expectations for the command order
        clear_plan();
        run_plan();
`ifdef PS2_SEQ_SAMPLE_RATE_EN
        lit = '{8'hFF, 8'hF3, 8'hC8, 8'hF4};
`else
        lit = '{8'hFF, 8'hF4};
`endif
        chk("nominal_sends", sent_log.size(), lit.size());
        for (int i = 0; i < lit.size() && i < sent_log.size(); i++)
            chk("nominal_cmd", sent_log[i], lit[i]);
        chk("nominal_initDone", bus.initDone, 1);
        chk("nominal_step", bus.step, NSTEP - 1);

        // bytes and txDone arriving in IDLE change nothing
        base = sends;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.rxData = (i == 0) ? 8'hFA : 8'hFE;
            bus.rxValid = 1'b1;
            bus.txDone = (i == 2);
        end
        repeat (4) tick();
        chk("idle_initDone", bus.initDone, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_no_send", sends - base, 0);

        // NACK on the first enable command
        clear_plan();
        fails[NSTEP-1] = 1; kinds[NSTEP-1][0] = 1;
        run_plan();
        cnt = 0;
        foreach (sent_log[i]) if (sent_log[i] == 8'hF4) cnt++;
        chk("nack_f4_sends", cnt, 2);
        chk("nack_initDone", bus.initDone, 1);

        // silent device: four 0xFF attempts then failure at step 0
        clear_plan();
        fails[0] = MR + 1;
        for (int k = 0; k < 5; k++) kinds[0][k] = 2;
        run_plan();
        chk("timeout_sends", sent_log.size(), 4);
        chk("timeout_error", bus.error, 1);
        chk("timeout_step", bus.step, 0);
        chk("timeout_initDone", bus.initDone, 0);

        // reset while waiting for BAT, then a clean run
        expq.delete();
        expq.push_back(8'hFF);
        tick();
        bus.start = 1'b1;
        exp_at = cyc + 2;
        wait_send();
        tick();
        bus.txDone = 1'b1;
        d = cyc;
        respond(1, d, 8'hFA, 1'b0, a);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        repeat (3) tick();
        reset = 1'b0;
        base = sends;
        repeat (20) tick();
        chk("no_send_after_reset", sends - base, 0);
        clear_plan();
        run_plan();
        chk("after_reset_initDone", bus.initDone, 1);

        // randomised runs
        for (int r = 0; r < 30; r++) begin
            clear_plan();
            for (int s = 0; s < NSTEP; s++) begin
                int q = $urandom_range(19, 0);
                fails[s] = (q < 11) ? 0 : (q < 16) ? 1 : (q < 18) ? 2 : (q < 19) ? 3 : MR + 1;
                for (int k = 0; k < 5; k++)
                    kinds[s][k] = (s == 0) ? $urandom_range(5, 1) : $urandom_range(2, 1);
            end
            run_plan();
            repeat ($urandom_range(3, 0)) tick();
        end

        finish_now();
    end
endmodule
